// File: rtl/g_lut_arbiter_if.sv
// Requester-side bus of the g(Z) LUT arbiter: lookup requests in, one-hot results out.
// Latency: wires only; timing is set by the arbiter.
// Backpressure: req_ready gates each request; responses are never stalled.
interface g_lut_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [6*N_REQ-1:0] req_pixel;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [11:0]        rsp_data;

  // Requester side
  modport master (
    output req_valid, req_pixel,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_pixel,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/g_lut_arbiter.sv
// Round-robin share of one registered camera-response LUT among N_REQ requesters; optional stats via G_LUT_ARB_STATS_EN.
// Latency: result returned exactly 2 cycles after acceptance; one lookup per cycle sustained.
// Backpressure: one-hot combinational req_ready per cycle; responses are never backpressured.
module g_lut_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  g_lut_arbiter_if.slave       bus,
  output logic                 lut_clk_en,
  output logic [5:0]           lut_pixel,
  input  logic [11:0]          lut_data,
  output logic                 idle
`ifdef G_LUT_ARB_STATS_EN
  ,
  output logic [15:0]          stat_grants,
  output logic [15:0]          stat_stall
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST_ID = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      gnt_id;
  logic               gnt_found;
  logic               grant;
  logic [N_REQ-1:0]   gnt_oh;
  logic               s1_valid;
  logic [PW-1:0]      s1_id;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [11:0]        rsp_data_q;

  // Round-robin search: first valid requester at or after ptr, wrapping at N_REQ-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + PW'(1);
    end
  end

  // Grant only while running and out of reset; drive the LUT address and enable
  always_comb begin
    grant      = gnt_found && rst_n && (state == RUN);
    gnt_oh     = grant ? (N_REQ'(1) << gnt_id) : '0;
    lut_clk_en = grant;
    lut_pixel  = grant ? bus.req_pixel[6*int'(gnt_id) +: 6] : 6'd0;
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; DRAIN waits for both pipeline stages to empty and ignores arb_en
  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (arb_en) state_nxt = RUN;
      end
      RUN: begin
        if (!arb_en) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && (rsp_valid_q == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lookup pipeline: tag the grant with the LUT access, then pair it with lut_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        s1_id <= gnt_id;
        ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + PW'(1);
      end
      rsp_valid_q <= s1_valid ? (N_REQ'(1) << s1_id) : '0;
      if (s1_valid) rsp_data_q <= lut_data;
    end
  end

`ifdef G_LUT_ARB_STATS_EN
  // Saturating counters of accepted lookups and RUN cycles that left a requester waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant && (stat_grants != 16'hFFFF)) stat_grants <= stat_grants + 16'd1;
      if ((state == RUN) && (|(bus.req_valid & ~gnt_oh)) && (stat_stall != 16'hFFFF))
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_g_lut_arbiter.sv
// Directed bench for g_lut_arbiter with a registered, clock-enabled LUT model.
// Latency: checks the 2-cycle accept-to-response timing and drain/reset sequencing.
// Backpressure: requesters hold req_valid independent of req_ready.
module tb_g_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b0;
  logic        lut_clk_en;
  logic [5:0]  lut_pixel;
  logic [11:0] lut_data = 12'h000;
  logic        idle;
  int          checks = 0;
  int          errors = 0;
`ifdef G_LUT_ARB_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_stall;
`endif

  g_lut_arbiter_if #(.N_REQ(3)) bus ();

  g_lut_arbiter #(.N_REQ(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .bus        (bus),
    .lut_clk_en (lut_clk_en),
    .lut_pixel  (lut_pixel),
    .lut_data   (lut_data),
    .idle       (idle)
`ifdef G_LUT_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lut_fn(input logic [5:0] p);
    case (p)
      6'h01:   lut_fn = 12'h03B;
      6'h20:   lut_fn = 12'h2CA;
      6'h3F:   lut_fn = 12'h468;
      default: lut_fn = {6'h15, p};
    endcase
  endfunction

  // Registered camera-response LUT, updates only when enabled
  always @(posedge clk) if (lut_clk_en) lut_data <= lut_fn(lut_pixel);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req_valid = 3'b111;
    arb_en = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
    checks++; if (lut_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", lut_clk_en); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 12'h000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 000", bus.rsp_data); end
    bus.req_valid = 3'b000;
    rst_n = 1'b1;
    step();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_run_entry: idle got %b expected 0", idle); end
  endtask

  task automatic test_single;
    bus.req_pixel = {6'h01, 6'h20, 6'h01};
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", bus.req_ready); end
    checks++; if (lut_clk_en !== 1'b1) begin errors++; $display("FAIL single_clk_en: got %b expected 1", lut_clk_en); end
    checks++; if (lut_pixel !== 6'h01) begin errors++; $display("FAIL single_pixel: got %h expected 01", lut_pixel); end
    step();
    bus.req_valid = 3'b000;
    #1;
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL single_rsp_early: got %b expected 000", bus.rsp_valid); end
    step();
    checks++; if (bus.rsp_valid !== 3'b001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 12'h03B) begin errors++; $display("FAIL single_rsp_data: got %h expected 03B", bus.rsp_data); end
    step();
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL single_rsp_pulse: got %b expected 000", bus.rsp_valid); end
  endtask

  task automatic test_contention;
    logic [2:0]  exp_g [4];
    logic [5:0]  exp_p [4];
    logic [11:0] exp_d [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_p = '{6'h3F, 6'h20, 6'h01, 6'h3F};
    exp_d = '{12'h468, 12'h2CA, 12'h03B, 12'h468};
    bus.req_pixel = {6'h01, 6'h20, 6'h3F};
    // ptr is 1 here; a lone grant to requester 2 brings it back to 0
    bus.req_valid = 3'b100;
    step();
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = (k < 4) ? 3'b111 : 3'b000;
      #1;
      if (k < 4) begin
        checks++; if (bus.req_ready !== exp_g[k]) begin errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_g[k]); end
        checks++; if (lut_pixel !== exp_p[k]) begin errors++; $display("FAIL contention_pixel[%0d]: got %h expected %h", k, lut_pixel, exp_p[k]); end
      end
      if (k >= 2) begin
        checks++; if (bus.rsp_valid !== exp_g[k-2]) begin errors++; $display("FAIL contention_rsp_valid[%0d]: got %b expected %b", k-2, bus.rsp_valid, exp_g[k-2]); end
        checks++; if (bus.rsp_data !== exp_d[k-2]) begin errors++; $display("FAIL contention_rsp_data[%0d]: got %h expected %h", k-2, bus.rsp_data, exp_d[k-2]); end
      end
      step();
    end
  endtask

  task automatic test_wrap;
    // ptr is 1; granting requester 1 moves it to 2
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = 3'b101;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL wrap_first: got %b expected 100", bus.req_ready); end
    step();
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL wrap_second: got %b expected 001", bus.req_ready); end
    step();
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL wrap_ptr_end: got %b expected 010", bus.req_ready); end
    step();
    bus.req_valid = 3'b000;
    step();
    step();
    step();
  endtask

  task automatic test_drain;
    // ptr is 2; requester 1 is the only one asking
    bus.req_valid = 3'b010;
    arb_en = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL drain_grant: got %b expected 010", bus.req_ready); end
    checks++; if (lut_pixel !== 6'h20) begin errors++; $display("FAIL drain_pixel: got %h expected 20", lut_pixel); end
    step();
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL drain_t1_ready: got %b expected 000", bus.req_ready); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drain_t1_idle: got %b expected 0", idle); end
    step();
    checks++; if (bus.rsp_valid !== 3'b010) begin errors++; $display("FAIL drain_rsp_valid: got %b expected 010", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 12'h2CA) begin errors++; $display("FAIL drain_rsp_data: got %h expected 2CA", bus.rsp_data); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL drain_t2_ready: got %b expected 000", bus.req_ready); end
    arb_en = 1'b1;
    step();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drain_t3_idle: got %b expected 0", idle); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL drain_t3_ready: got %b expected 000", bus.req_ready); end
    step();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drain_t4_idle: got %b expected 1", idle); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL drain_t4_ready: got %b expected 000", bus.req_ready); end
    bus.req_valid = 3'b000;
    step();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drain_rerun_idle: got %b expected 0", idle); end
  endtask

  task automatic test_reset_mid;
    bus.req_pixel = {6'h01, 6'h20, 6'h3F};
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_grant: got %b expected 001", bus.req_ready); end
    checks++; if (lut_pixel !== 6'h3F) begin errors++; $display("FAIL rstmid_pixel: got %h expected 3F", lut_pixel); end
    step();
    bus.req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL rstmid_ready: got %b expected 000", bus.req_ready); end
    checks++; if (lut_clk_en !== 1'b0) begin errors++; $display("FAIL rstmid_clk_en: got %b expected 0", lut_clk_en); end
    step();
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL rstmid_rsp0: got %b expected 000", bus.rsp_valid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", idle); end
    step();
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL rstmid_rsp1: got %b expected 000", bus.rsp_valid); end
    bus.req_valid = 3'b000;
    rst_n = 1'b1;
    step();
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_ptr0: got %b expected 001", bus.req_ready); end
    bus.req_valid = 3'b000;
    step();
    step();
    step();
  endtask

`ifdef G_LUT_ARB_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    arb_en = 1'b1;
    step();
    checks++; if (stat_grants !== 16'd0) begin errors++; $display("FAIL stats_grants_clr: got %0d expected 0", stat_grants); end
    checks++; if (stat_stall !== 16'd0) begin errors++; $display("FAIL stats_stall_clr: got %0d expected 0", stat_stall); end
    bus.req_valid = 3'b111;
    for (int k = 0; k < 4; k++) step();
    bus.req_valid = 3'b000;
    #1;
    checks++; if (stat_grants !== 16'd4) begin errors++; $display("FAIL stats_grants: got %0d expected 4", stat_grants); end
    checks++; if (stat_stall !== 16'd4) begin errors++; $display("FAIL stats_stall: got %0d expected 4", stat_stall); end
    step();
  endtask
`endif

  initial begin
    bus.req_valid = 3'b000;
    bus.req_pixel = {6'h01, 6'h20, 6'h3F};
    step();
    step();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_drain();
    test_reset_mid();
`ifdef G_LUT_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
